sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
Successive-approximation controller that drives the B operand of an external magnitude comparator and consumes its greater/equal/lesser flags to determine the comparator's A operand (target) MSB-first. It is the initiator/consumer for the team's comparator: it issues trial values and reads back the relation flags. It is used for threshold search and SAR-style conversion in the same datapath.

Parameters:
WIDTH, 4, operand width; matches the comparator A/B width.
SETTLE, 1, cycles each trial value is held before the flags are sampled; legal range 1..15.

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  begin a search; sampled only in IDLE.
guess  output  WIDTH  trial value driven to the comparator B input; registered.
cmp_greater  input  1  comparator flag, A > guess.
cmp_equal  input  1  comparator flag, A == guess.
cmp_lesser  input  1  comparator flag, A < guess.
busy  output  1  high while in TRY.
done  output  1  one-cycle pulse when the search ends.
result  output  WIDTH  search result; held until the next accepted start.
exact  output  1  equal flag seen at the final sample; held with result.
err  output  1  flags not one-hot at a sample; held with result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; guess, result = 0; busy, done, exact, err = 0; settle counter = 0.
- States: IDLE, TRY, DONE.
- IDLE:
  - guess=0.
  - start=1 at an edge moves to TRY and sets:
    - guess = 1<<(WIDTH-1)
    - bit index = WIDTH-1
    - settle count = SETTLE-1
    - result, exact, err cleared.
- TRY (busy=1): guess is stable throughout. Each edge with settle count != 0 decrements the count. The edge with count == 0 samples the flags:
  - Flags not exactly one-hot (covers the comparator's all-zero reset output): err=1, result = guess with the current bit cleared, go to DONE.
  - cmp_equal: result = guess, exact=1, go to DONE (early exit).
  - cmp_greater: keep the current bit.
  - cmp_lesser: clear the current bit.
  - After a keep or clear:
    - If bit index = 0: result = kept value, go to DONE.
    - Otherwise: guess = kept value | (1 << (index-1)), index decrements, count reloads to SETTLE-1.
- DONE: done=1 for exactly one cycle, busy=0. guess returns to 0. Next state is IDLE unconditionally.
- start is ignored in TRY and DONE; there is no queuing. start held high re-triggers on the first IDLE edge after DONE.
- Latency: start edge to done cycle = (samples × SETTLE) + 1 cycles. Samples range from 1 to WIDTH.
- With an honest comparator, result equals A always; exact=0 is possible only if the search runs all WIDTH samples without ever seeing equal. With WIDTH=4, that happens only for A=0.
- Reset mid-search aborts immediately to the reset state. No done is issued.
- Flag changes between sample edges are ignored.

Test Plan:
- SETTLE=1, A=5, start pulse: guesses 8,4,6,5 on consecutive cycles; flags L,G,L,E. Then done pulses 5 cycles after the start edge with result=5, exact=1, err=0.
- SETTLE=1, A=8: a single guess of 8 returns E. done pulses 2 cycles after the start edge with result=8, exact=1, and busy was high exactly 1 cycle.
- SETTLE=1, A=0: guesses 8,4,2,1 all return L. Result=0, exact=0, done 5 cycles after start.
- SETTLE=3, A=15: guesses 8,12,14,15, each held 3 cycles; flags G,G,G,E. done 13 cycles after start, result=15, exact=1.
- Hold all flags at 0 (comparator in reset) and start: at the first sample err=1, result=0, done pulse. A subsequent start with a valid A=3 clears err and returns result=3.
- Deassert reset_n two cycles into a search for A=9: guess, busy, result, done are 0 immediately with no done pulse. After release, start with A=9 returns result=9. A start asserted during busy has no effect.

Source files
------------

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
//   Successive-approximation search controller. It drives trial values onto
//   the B operand of an external magnitude comparator and reads back its
//   greater/equal/lesser flags to resolve the comparator's A operand MSB-first.
//   Each trial is held for SETTLE cycles before the flags are sampled.
//
// Parameters
//   WIDTH   operand width (matches the comparator A/B width)
//   SETTLE  cycles each trial is held before sampling, 1..15
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   begin a search (sampled only in IDLE)
//   guess        out  registered trial value to the comparator B input
//   cmp_greater  in   comparator flag A >  guess
//   cmp_equal    in   comparator flag A == guess
//   cmp_lesser   in   comparator flag A <  guess
//   busy         out  high while a search is running
//   done         out  one-cycle pulse when a search ends
//   result       out  search result, held until the next accepted start
//   exact        out  equal flag seen at the final sample
//   err          out  flags were not one-hot at a sample
module sar_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_greater,
    input  logic             cmp_equal,
    input  logic             cmp_lesser,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB        = ONE << (WIDTH - 1);
    localparam logic [IW-1:0]    IDX_TOP    = IW'(WIDTH - 1);
    localparam logic [3:0]       CNT_RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exact_q, exact_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] cur_bit;
    logic [WIDTH-1:0] kept;
    logic             flags_onehot;

    // Bit currently under test and the trial value after resolving it.
    assign cur_bit = ONE << idx_q;
    assign kept    = cmp_greater ? guess_q : (guess_q & ~cur_bit);

    // All-zero flags (comparator still in reset) or multiple flags are
    // treated as a broken comparator rather than a decision.
    assign flags_onehot = ({cmp_greater, cmp_equal, cmp_lesser} == 3'b100) ||
                          ({cmp_greater, cmp_equal, cmp_lesser} == 3'b010) ||
                          ({cmp_greater, cmp_equal, cmp_lesser} == 3'b001);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exact_q  <= exact_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exact_d  = exact_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                guess_d = '0;
                if (start) begin
                    state_d  = TRY;
                    guess_d  = MSB;
                    idx_d    = IDX_TOP;
                    cnt_d    = CNT_RELOAD;
                    result_d = '0;
                    exact_d  = 1'b0;
                    err_d    = 1'b0;
                end
            end

            TRY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!flags_onehot) begin
                    err_d    = 1'b1;
                    result_d = guess_q & ~cur_bit;
                    guess_d  = '0;
                    state_d  = DONE;
                end else if (cmp_equal) begin
                    // Exact hit: remaining bits are already zero in guess.
                    result_d = guess_q;
                    exact_d  = 1'b1;
                    guess_d  = '0;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    result_d = kept;
                    guess_d  = '0;
                    state_d  = DONE;
                end else begin
                    guess_d = kept | (cur_bit >> 1);
                    idx_d   = idx_q - IW'(1);
                    cnt_d   = CNT_RELOAD;
                end
            end

            DONE: begin
                guess_d = '0;
                state_d = IDLE;
            end

            default: begin
                guess_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign guess  = guess_q;
    assign busy   = (state_q == TRY);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign exact  = exact_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
module tb_sar_search_ctrl;

    logic       clk;
    logic       reset_n;

    // Instance with SETTLE=1
    logic       start1;
    logic [3:0] guess1, result1, a1;
    logic       g1, e1, l1, zero1;
    logic       busy1, done1, exact1, err1;

    // Instance with SETTLE=3
    logic       start3;
    logic [3:0] guess3, result3, a3;
    logic       g3, e3, l3;
    logic       busy3, done3, exact3, err3;

    int pass_cnt;
    int total_cnt;
    int fail_cnt;

    sar_search_ctrl #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .guess(guess1),
        .cmp_greater(g1), .cmp_equal(e1), .cmp_lesser(l1),
        .busy(busy1), .done(done1), .result(result1), .exact(exact1), .err(err1)
    );

    sar_search_ctrl #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .guess(guess3),
        .cmp_greater(g3), .cmp_equal(e3), .cmp_lesser(l3),
        .busy(busy3), .done(done3), .result(result3), .exact(exact3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural comparator: A is the bench-chosen target, B is the DUT guess.
    always_comb begin
        g1 = 1'b0; e1 = 1'b0; l1 = 1'b0;
        if (!zero1) begin
            g1 = (a1 > guess1);
            e1 = (a1 == guess1);
            l1 = (a1 < guess1);
        end
    end

    always_comb begin
        g3 = (a3 > guess3);
        e3 = (a3 == guess3);
        l3 = (a3 < guess3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive start for one edge, return at the negedge of the first TRY cycle.
    task automatic kick1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        fail_cnt  = 0;
        reset_n   = 1'b0;
        start1    = 1'b0;
        start3    = 1'b0;
        a1        = 4'd0;
        a3        = 4'd0;
        zero1     = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_guess",  32'(guess1),  0);
        chk("rst_busy",   32'(busy1),   0);
        chk("rst_done",   32'(done1),   0);
        chk("rst_result", 32'(result1), 0);
        chk("rst_exact",  32'(exact1),  0);
        chk("rst_err",    32'(err1),    0);
        reset_n = 1'b1;
        @(negedge clk);

        // A=5, SETTLE=1: 8(L) 4(G) 6(L) 5(E), done in cycle 5
        a1 = 4'd5;
        kick1();
        chk("a5_g8",    32'(guess1), 8);
        chk("a5_busy",  32'(busy1),  1);
        @(negedge clk); chk("a5_g4", 32'(guess1), 4);
        @(negedge clk); chk("a5_g6", 32'(guess1), 6);
        @(negedge clk); chk("a5_g5", 32'(guess1), 5);
        chk("a5_nodone", 32'(done1), 0);
        @(negedge clk);
        chk("a5_done",   32'(done1),   1);
        chk("a5_busy0",  32'(busy1),   0);
        chk("a5_result", 32'(result1), 5);
        chk("a5_exact",  32'(exact1),  1);
        chk("a5_err",    32'(err1),    0);
        chk("a5_gzero",  32'(guess1),  0);
        @(negedge clk);
        chk("a5_pulse",  32'(done1),   0);
        chk("a5_hold",   32'(result1), 5);

        // A=8: single guess hits equal, done in cycle 2
        a1 = 4'd8;
        kick1();
        chk("a8_g8",   32'(guess1), 8);
        chk("a8_busy", 32'(busy1),  1);
        @(negedge clk);
        chk("a8_done",   32'(done1),   1);
        chk("a8_busy0",  32'(busy1),   0);
        chk("a8_result", 32'(result1), 8);
        chk("a8_exact",  32'(exact1),  1);
        @(negedge clk);

        // A=0: 8,4,2,1 all lesser, no exact
        a1 = 4'd0;
        kick1();
        chk("a0_g8", 32'(guess1), 8);
        @(negedge clk); chk("a0_g4", 32'(guess1), 4);
        @(negedge clk); chk("a0_g2", 32'(guess1), 2);
        @(negedge clk); chk("a0_g1", 32'(guess1), 1);
        @(negedge clk);
        chk("a0_done",   32'(done1),   1);
        chk("a0_result", 32'(result1), 0);
        chk("a0_exact",  32'(exact1),  0);
        @(negedge clk);

        // SETTLE=3, A=15: 8,12,14,15 each held 3 cycles, done in cycle 13
        a3 = 4'd15;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("s3_g8a", 32'(guess3), 8);
        @(negedge clk); chk("s3_g8b", 32'(guess3), 8);
        @(negedge clk); chk("s3_g8c", 32'(guess3), 8);
        @(negedge clk); chk("s3_g12", 32'(guess3), 12);
        repeat (3) @(negedge clk);
        chk("s3_g14",  32'(guess3), 14);
        repeat (3) @(negedge clk);
        chk("s3_g15a", 32'(guess3), 15);
        repeat (2) @(negedge clk);
        chk("s3_g15c",  32'(guess3), 15);
        chk("s3_busy",  32'(busy3),  1);
        chk("s3_nodone", 32'(done3), 0);
        @(negedge clk);
        chk("s3_done",   32'(done3),   1);
        chk("s3_result", 32'(result3), 15);
        chk("s3_exact",  32'(exact3),  1);
        @(negedge clk);

        // All flags zero: err on the first sample, result=8 with bit 3 cleared
        zero1 = 1'b1;
        kick1();
        chk("z_g8", 32'(guess1), 8);
        @(negedge clk);
        chk("z_done",   32'(done1),   1);
        chk("z_err",    32'(err1),    1);
        chk("z_result", 32'(result1), 0);
        chk("z_exact",  32'(exact1),  0);
        @(negedge clk);
        zero1 = 1'b0;

        // Recovery with A=3: 8(L) 4(L) 2(G) 3(E)
        a1 = 4'd3;
        kick1();
        chk("r3_errclr", 32'(err1), 0);
        @(negedge clk); chk("r3_g4", 32'(guess1), 4);
        @(negedge clk); chk("r3_g2", 32'(guess1), 2);
        @(negedge clk); chk("r3_g3", 32'(guess1), 3);
        @(negedge clk);
        chk("r3_done",   32'(done1),   1);
        chk("r3_result", 32'(result1), 3);
        chk("r3_err",    32'(err1),    0);
        @(negedge clk);

        // Reset two cycles into a search for A=9
        a1 = 4'd9;
        kick1();
        @(negedge clk);
        chk("rs_g12", 32'(guess1), 12);
        #2 reset_n = 1'b0;
        #1;
        chk("rs_guess",  32'(guess1),  0);
        chk("rs_busy",   32'(busy1),   0);
        chk("rs_result", 32'(result1), 0);
        chk("rs_done",   32'(done1),   0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rs_nodone", 32'(done1), 0);

        // A=9 after reset: 8(G) 12(L) 10(L) 9(E); a start during busy is ignored
        kick1();
        chk("p9_g8", 32'(guess1), 8);
        @(negedge clk);
        chk("p9_g12", 32'(guess1), 12);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("p9_g10", 32'(guess1), 10);
        @(negedge clk); chk("p9_g9", 32'(guess1), 9);
        @(negedge clk);
        chk("p9_done",   32'(done1),   1);
        chk("p9_result", 32'(result1), 9);
        chk("p9_exact",  32'(exact1),  1);
        @(negedge clk);
        chk("p9_idle", 32'(busy1), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
